// File: rtl/mem_stage_ls.sv
// MEM stage: pipeline register, byte/half/word load extract and extend, variable-latency SRAM wait.
// Latency: loads answered in the holding cycle pass through combinationally; each SRAM wait cycle adds one stall.
// Backpressure: stallreq_mem is high while an aligned load waits for rvalid; optional MEM_TIMEOUT_EN bounds that wait.
module mem_stage_ls #(
   parameter int STALL_W = 6,
   parameter int STAGE   = 3,
   parameter int PC_W    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic [PC_W-1:0]    ex_pc,
   input  logic [2:0]         ex_ld_op,
   input  logic [1:0]         ex_addr_lo,
   input  logic               ex_sel_mem,
   input  logic               ex_rf_we,
   input  logic [4:0]         ex_rf_waddr,
   input  logic [31:0]        ex_result,
   input  logic [31:0]        data_sram_rdata,
   input  logic               data_sram_rvalid,
   output logic [PC_W-1:0]    mem_pc,
   output logic               mem_rf_we,
   output logic [4:0]         mem_rf_waddr,
   output logic [31:0]        mem_rf_wdata,
   output logic               mem_misalign,
   output logic               stallreq_mem,
   output logic               mem_bus_err
);

   localparam logic [2:0] OP_LB  = 3'b001;
   localparam logic [2:0] OP_LBU = 3'b010;
   localparam logic [2:0] OP_LH  = 3'b011;
   localparam logic [2:0] OP_LHU = 3'b100;
   localparam logic [2:0] OP_LW  = 3'b101;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [2:0]      ld_op;
      logic [1:0]      addr_lo;
      logic            sel_mem;
      logic            rf_we;
      logic [4:0]      rf_waddr;
      logic [31:0]     result;
   } mem_reg_t;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   function automatic logic is_load(input logic [2:0] op);
      return (op >= OP_LB) && (op <= OP_LW);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
      return (((op == OP_LH) || (op == OP_LHU)) && lo[0]) ||
             ((op == OP_LW) && (lo != 2'b00));
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] op, input logic [1:0] lo,
                                          input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lo)
         2'b00:   b = d[7:0];
         2'b01:   b = d[15:8];
         2'b10:   b = d[23:16];
         default: b = d[31:24];
      endcase
      h = lo[1] ? d[31:16] : d[15:0];
      case (op)
         OP_LB:   r = {{24{b[7]}}, b};
         OP_LBU:  r = {24'h0, b};
         OP_LH:   r = {{16{h[15]}}, h};
         OP_LHU:  r = {16'h0, h};
         OP_LW:   r = d;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   mem_reg_t    r;
   mem_reg_t    ex_in;
   state_t      st;
   logic [31:0] ld_buf;
   logic [31:0] ld_ext;
   logic [31:0] ld_data;
   logic        bubble;
   logic        capture;
   logic        misalign;
   logic        wait_miss;
   logic        bus_err;
   logic        unused_stall;

   assign ex_in = '{pc: ex_pc, ld_op: ex_ld_op, addr_lo: ex_addr_lo, sel_mem: ex_sel_mem,
                    rf_we: ex_rf_we, rf_waddr: ex_rf_waddr, result: ex_result};

   assign bubble       = stall[STAGE] & ~stall[STAGE+1];
   assign capture      = ~stall[STAGE];
   assign unused_stall = ^stall;

   // Pipeline register: reset, bubble, capture, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst)          r <= '0;
      else if (bubble)  r <= '0;
      else if (capture) r <= ex_in;
   end

   assign misalign  = is_load(r.ld_op) & is_misaligned(r.ld_op, r.addr_lo);
   assign wait_miss = (st == WAIT) & ~data_sram_rvalid;
   assign ld_ext    = extend(r.ld_op, r.addr_lo, data_sram_rdata);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   logic [CNT_W-1:0] tmo_cnt;
   logic             bus_err_q;
   assign bus_err = bus_err_q;
`else
   logic unused_timeout;
   assign bus_err        = 1'b0;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   // Load FSM: enter WAIT on capture of an aligned load, buffer the answer, optionally time out.
   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= IDLE;
         ld_buf <= '0;
`ifdef MEM_TIMEOUT_EN
         tmo_cnt   <= '0;
         bus_err_q <= 1'b0;
`endif
      end else if (bubble) begin
         st <= IDLE;
`ifdef MEM_TIMEOUT_EN
         bus_err_q <= 1'b0;
`endif
      end else if (capture) begin
         st <= (is_load(ex_ld_op) && !is_misaligned(ex_ld_op, ex_addr_lo)) ? WAIT : IDLE;
`ifdef MEM_TIMEOUT_EN
         tmo_cnt   <= '0;
         bus_err_q <= 1'b0;
`endif
      end else if (st == WAIT) begin
         if (data_sram_rvalid) begin
            st     <= DONE;
            ld_buf <= ld_ext;
         end
`ifdef MEM_TIMEOUT_EN
         else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
            st        <= DONE;
            ld_buf    <= '0;
            bus_err_q <= 1'b1;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
`endif
      end
   end

   // Load data source: bypass in the rvalid cycle, buffer afterwards, zero while still waiting.
   always_comb begin
      ld_data = 32'h0;
      if (st == DONE)                          ld_data = ld_buf;
      else if ((st == WAIT) && data_sram_rvalid) ld_data = ld_ext;
   end

   assign mem_pc       = r.pc;
   assign mem_rf_waddr = r.rf_waddr;
   assign mem_rf_wdata = r.sel_mem ? ld_data : r.result;
   assign mem_rf_we    = r.rf_we & ~misalign & ~wait_miss & ~bus_err;
   assign mem_misalign = misalign;
   assign stallreq_mem = wait_miss;
   assign mem_bus_err  = bus_err;

endmodule

// File: tb/tb_mem_stage_ls.sv
module tb_mem_stage_ls;

`ifdef MEM_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 16;
`endif
   localparam int STALL_W = 6;
   localparam int STAGE   = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic [STALL_W-1:0] stall;
   logic [31:0]        ex_pc;
   logic [2:0]         ex_ld_op;
   logic [1:0]         ex_addr_lo;
   logic               ex_sel_mem;
   logic               ex_rf_we;
   logic [4:0]         ex_rf_waddr;
   logic [31:0]        ex_result;
   logic [31:0]        data_sram_rdata;
   logic               data_sram_rvalid;
   logic [31:0]        mem_pc;
   logic               mem_rf_we;
   logic [4:0]         mem_rf_waddr;
   logic [31:0]        mem_rf_wdata;
   logic               mem_misalign;
   logic               stallreq_mem;
   logic               mem_bus_err;

   int checks   = 0;
   int failures = 0;

   mem_stage_ls #(.STALL_W(STALL_W), .STAGE(STAGE), .PC_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .ex_pc(ex_pc), .ex_ld_op(ex_ld_op), .ex_addr_lo(ex_addr_lo), .ex_sel_mem(ex_sel_mem),
      .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
      .data_sram_rdata(data_sram_rdata), .data_sram_rvalid(data_sram_rvalid),
      .mem_pc(mem_pc), .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
      .mem_rf_wdata(mem_rf_wdata), .mem_misalign(mem_misalign),
      .stallreq_mem(stallreq_mem), .mem_bus_err(mem_bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  lo;
      logic        sel;
      logic        we;
      logic [31:0] result;
      logic [31:0] rdata;
      logic        rvalid;
      logic [31:0] e_wdata;
      logic        e_we;
      logic        e_mis;
      logic        e_sr;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Capture one EX instruction, then hold the register for the following cycle.
   task automatic cap(input logic [2:0] op, input logic [1:0] lo, input logic sel, input logic we,
                      input logic [4:0] wa, input logic [31:0] res, input logic [31:0] pc);
      ex_ld_op = op; ex_addr_lo = lo; ex_sel_mem = sel; ex_rf_we = we;
      ex_rf_waddr = wa; ex_result = res; ex_pc = pc;
      stall = '0; data_sram_rvalid = 1'b0;
      tick();
      stall = '1;
   endtask

   vec_t vecs[15];

   initial begin
      // op, lo, sel, we, result, rdata, rvalid, wdata, we, misalign, stallreq
      vecs[0]  = '{3'b001, 2'b11, 1'b1, 1'b1, 32'h0,         32'h80FF_1234, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{3'b010, 2'b11, 1'b1, 1'b1, 32'h0,         32'h80FF_1234, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{3'b001, 2'b00, 1'b1, 1'b1, 32'h0,         32'h1234_56F0, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{3'b010, 2'b01, 1'b1, 1'b1, 32'h0,         32'h1234_56F0, 1'b1, 32'h0000_0056, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{3'b001, 2'b10, 1'b1, 1'b1, 32'h0,         32'h1234_56F0, 1'b1, 32'h0000_0034, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{3'b011, 2'b00, 1'b1, 1'b1, 32'h0,         32'h1234_8001, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{3'b100, 2'b10, 1'b1, 1'b1, 32'h0,         32'h9ABC_0000, 1'b1, 32'h0000_9ABC, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{3'b011, 2'b10, 1'b1, 1'b1, 32'h0,         32'h7FFF_0000, 1'b1, 32'h0000_7FFF, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{3'b101, 2'b00, 1'b1, 1'b1, 32'h0,         32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{3'b101, 2'b01, 1'b1, 1'b1, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{3'b011, 2'b01, 1'b1, 1'b1, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{3'b100, 2'b11, 1'b1, 1'b1, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{3'b000, 2'b00, 1'b0, 1'b1, 32'h1111_2222, 32'hDEAD_BEEF, 1'b0, 32'h1111_2222, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{3'b110, 2'b01, 1'b0, 1'b1, 32'h3333_4444, 32'hDEAD_BEEF, 1'b0, 32'h3333_4444, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{3'b101, 2'b00, 1'b1, 1'b1, 32'h0,         32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; stall = '0; ex_pc = '0; ex_ld_op = '0; ex_addr_lo = '0; ex_sel_mem = 1'b0;
      ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_result = '0;
      data_sram_rdata = '0; data_sram_rvalid = 1'b0;
      tick();
      tick();
      #2;
      chk("rst_pc", mem_pc, 32'h0);
      chk("rst_we", {31'h0, mem_rf_we}, 32'h0);
      chk("rst_waddr", {27'h0, mem_rf_waddr}, 32'h0);
      chk("rst_wdata", mem_rf_wdata, 32'h0);
      chk("rst_mis", {31'h0, mem_misalign}, 32'h0);
      chk("rst_sr", {31'h0, stallreq_mem}, 32'h0);
      chk("rst_err", {31'h0, mem_bus_err}, 32'h0);
      rst = 1'b0;

      // Table: capture, then check in the holding cycle with the given SRAM response.
      for (int i = 0; i < 15; i++) begin
         cap(vecs[i].op, vecs[i].lo, vecs[i].sel, vecs[i].we, 5'(i + 1), vecs[i].result,
             32'h1000 + 32'(i * 4));
         data_sram_rdata  = vecs[i].rdata;
         data_sram_rvalid = vecs[i].rvalid;
         #2;
         chk($sformatf("v%0d_wdata", i), mem_rf_wdata, vecs[i].e_wdata);
         chk($sformatf("v%0d_we", i), {31'h0, mem_rf_we}, {31'h0, vecs[i].e_we});
         chk($sformatf("v%0d_mis", i), {31'h0, mem_misalign}, {31'h0, vecs[i].e_mis});
         chk($sformatf("v%0d_sr", i), {31'h0, stallreq_mem}, {31'h0, vecs[i].e_sr});
         chk($sformatf("v%0d_pc", i), mem_pc, 32'h1000 + 32'(i * 4));
         chk($sformatf("v%0d_waddr", i), {27'h0, mem_rf_waddr}, 32'(i + 1));
      end

      // LHU with three wait cycles, then buffered data held under downstream stall.
      cap(3'b100, 2'b10, 1'b1, 1'b1, 5'd7, 32'h0, 32'h2000);
      for (int c = 0; c < 3; c++) begin
         data_sram_rvalid = 1'b0; data_sram_rdata = 32'h5555_5555;
         #2;
         chk($sformatf("wait%0d_sr", c), {31'h0, stallreq_mem}, 32'h1);
         chk($sformatf("wait%0d_we", c), {31'h0, mem_rf_we}, 32'h0);
         chk($sformatf("wait%0d_wdata", c), mem_rf_wdata, 32'h0);
         tick();
      end
      data_sram_rvalid = 1'b1; data_sram_rdata = 32'h9ABC_0000;
      #2;
      chk("rv_wdata", mem_rf_wdata, 32'h0000_9ABC);
      chk("rv_we", {31'h0, mem_rf_we}, 32'h1);
      chk("rv_sr", {31'h0, stallreq_mem}, 32'h0);
      tick();
      for (int c = 0; c < 2; c++) begin
         data_sram_rvalid = 1'(c); data_sram_rdata = 32'hDEAD_BEEF;
         #2;
         chk($sformatf("done%0d_wdata", c), mem_rf_wdata, 32'h0000_9ABC);
         chk($sformatf("done%0d_we", c), {31'h0, mem_rf_we}, 32'h1);
         chk($sformatf("done%0d_sr", c), {31'h0, stallreq_mem}, 32'h0);
         tick();
      end

      // Bubble insertion.
      cap(3'b000, 2'b00, 1'b0, 1'b1, 5'd9, 32'h5555_AAAA, 32'h2400);
      data_sram_rvalid = 1'b0;
      #2;
      chk("pre_bub_wdata", mem_rf_wdata, 32'h5555_AAAA);
      stall = STALL_W'(1) << STAGE;
      tick();
      stall = '1;
      #2;
      chk("bub_pc", mem_pc, 32'h0);
      chk("bub_we", {31'h0, mem_rf_we}, 32'h0);
      chk("bub_waddr", {27'h0, mem_rf_waddr}, 32'h0);
      chk("bub_wdata", mem_rf_wdata, 32'h0);

      // Reset while a load waits.
      cap(3'b101, 2'b00, 1'b1, 1'b1, 5'd3, 32'h0, 32'h3000);
      #2;
      chk("prerst_sr", {31'h0, stallreq_mem}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #2;
      chk("mrst_sr", {31'h0, stallreq_mem}, 32'h0);
      chk("mrst_pc", mem_pc, 32'h0);
      chk("mrst_we", {31'h0, mem_rf_we}, 32'h0);
      chk("mrst_waddr", {27'h0, mem_rf_waddr}, 32'h0);
      chk("mrst_wdata", mem_rf_wdata, 32'h0);

`ifdef MEM_TIMEOUT_EN
      // SRAM never answers: four stall cycles, then bus error.
      cap(3'b101, 2'b00, 1'b1, 1'b1, 5'd4, 32'h0, 32'h4000);
      for (int c = 0; c < 4; c++) begin
         data_sram_rvalid = 1'b0;
         #2;
         chk($sformatf("tmo%0d_sr", c), {31'h0, stallreq_mem}, 32'h1);
         chk($sformatf("tmo%0d_err", c), {31'h0, mem_bus_err}, 32'h0);
         tick();
      end
      #2;
      chk("tmo_err", {31'h0, mem_bus_err}, 32'h1);
      chk("tmo_we", {31'h0, mem_rf_we}, 32'h0);
      chk("tmo_sr", {31'h0, stallreq_mem}, 32'h0);
      tick();
      data_sram_rvalid = 1'b1; data_sram_rdata = 32'h1234_5678;
      #2;
      chk("late_err", {31'h0, mem_bus_err}, 32'h1);
      chk("late_we", {31'h0, mem_rf_we}, 32'h0);
      chk("late_wdata", mem_rf_wdata, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage_ls.md
Name: mem_stage_ls

Overview:
- Parametrised MEM pipeline stage, successor to the single-cycle MEM stage. Registers the EX payload under the shared stall vector.
- Supports full load set (LB/LBU/LH/LHU/LW) with byte-lane select and sign/zero extension.
- Handles a variable-latency data SRAM via an rvalid handshake, raising a stall request while a load is outstanding.
- Drives WB and the ID forwarding network.

Parameters:
STALL_W, 6, width of stall vector (StallBus).
STAGE, 3, index of this stage in stall vector; STAGE+1 is downstream (WB).
PC_W, 32, PC width.
TIMEOUT, 16, max wait cycles for rvalid (used only with MEM_TIMEOUT_EN).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
stall  in  STALL_W  global stall vector; 1 = Stop.
ex_pc  in  PC_W  EX instruction PC.
ex_ld_op  in  3  000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; others treated as none.
ex_addr_lo  in  2  low two bits of data address.
ex_sel_mem  in  1  1 = writeback data comes from memory.
ex_rf_we  in  1  register write enable.
ex_rf_waddr  in  5  destination register.
ex_result  in  32  ALU result.
data_sram_rdata  in  32  SRAM read data.
data_sram_rvalid  in  1  rdata valid this cycle.
mem_pc  out  PC_W  registered PC.
mem_rf_we  out  1  final write enable (to WB and forwarding).
mem_rf_waddr  out  5  destination register.
mem_rf_wdata  out  32  final write data.
mem_misalign  out  1  current load is misaligned.
stallreq_mem  out  1  request pipeline stall.
mem_bus_err  out  1  load timed out (MEM_TIMEOUT_EN only; else tied 0).

Behaviour:
- Pipeline register, evaluated each posedge, in priority order:
  - rst: clear all fields to 0.
  - stall[STAGE]=1 and stall[STAGE+1]=0: insert bubble (all fields 0).
  - stall[STAGE]=0: capture EX inputs.
  - Otherwise: hold.
- is_load = registered ld_op in 001..101.
- Misalign rules:
  - LH/LHU with addr_lo[0]=1 → misaligned.
  - LW with addr_lo≠00 → misaligned.
  - Byte loads never misalign.
  - A misaligned load asserts mem_misalign, forces mem_rf_we=0, never waits.
- Extension:
  - LB/LBU select byte addr_lo (lane 0 = bits 7:0); LB sign-extends bit 7, LBU zero-extends.
  - LH/LHU select half addr_lo[1] (0 = 15:0); LH sign-extends bit 15, LHU zero-extends.
  - LW passes rdata unchanged.
- FSM states: IDLE, WAIT, DONE; reset → IDLE.
  - Any state → WAIT when the register captures an aligned load; → IDLE when it captures a non-load, misaligned load or bubble.
  - WAIT, rvalid=0: stallreq_mem=1.
  - WAIT, rvalid=1: stallreq_mem=0 that cycle; wdata = extended rdata (combinational bypass); extended value latched into ld_buf; → DONE unless the register advances the same edge.
  - DONE: stallreq_mem=0; wdata = ld_buf; rvalid ignored.
- Write data/enable:
  - mem_rf_wdata = sel_mem ? (load data per state; 0 while in WAIT without rvalid) : result.
  - mem_rf_we = rf_we & ~misalign & ~(WAIT & ~rvalid). Forwarding never sees stale data.
- Reset mid-WAIT: state → IDLE, ld_buf → 0, stallreq_mem → 0 the cycle after.
- Latency: non-load and zero-wait loads produce output in the same cycle the register holds them. An N-cycle SRAM adds N stall cycles.
- Reset values: every output 0.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter clears on WAIT entry and increments each WAIT cycle with rvalid=0.
  - When count reaches TIMEOUT: → DONE with ld_buf=0, mem_bus_err=1 and mem_rf_we=0 while that instruction remains; stallreq_mem drops.
  - rvalid arriving after timeout is ignored.
- Undefined: no counter; mem_bus_err tied 0; WAIT persists until rvalid.

Test Plan:
- LB, addr_lo=11, rdata=0x80FF_1234, rvalid same cycle → wdata=0xFFFF_FF80, we=1, stallreq 0.
- LHU, addr_lo=10, rdata=0x9ABC_0000, rvalid after 3 cycles → stallreq=1 for 3 cycles (we=0), then wdata=0x0000_9ABC, we=1.
- LW, addr_lo=01 → mem_misalign=1, we=0, stallreq=0, FSM IDLE.
- Load completes in WAIT, then stall[STAGE+1]=1 for 2 cycles with rdata changed to 0xDEAD_BEEF → wdata holds the buffered value.
- stall[STAGE]=1, stall[STAGE+1]=0 → next cycle all outputs 0 (bubble). rst asserted mid-WAIT → all outputs 0 next cycle.
- MEM_TIMEOUT_EN, TIMEOUT=4, rvalid never → stallreq high 4 cycles, then mem_bus_err=1, we=0, stallreq=0.
